// File: rtl/pipe_skid_reg.sv
// Two-entry skid register: main drives the output, skid absorbs one beat while the output stalls.
// Optional stall counter port and logic are built only when PIPE_SKID_STATS_EN is defined.
module pipe_skid_reg #(
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  flush
`ifdef PIPE_SKID_STATS_EN
  ,
  output logic [15:0]           stall_count
`endif
);

  if (DATA_WIDTH < 1) begin : g_bad_width
    $fatal(1, "pipe_skid_reg: DATA_WIDTH must be at least 1");
  end

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StBusy  = 2'd1,
    StFull  = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] main_q, main_d;
  logic [DATA_WIDTH-1:0] skid_q, skid_d;
  logic                  in_ready_q;
  logic                  in_fire, out_fire;

  assign in_ready  = in_ready_q;
  assign out_valid = (state_q != StEmpty);
  assign out_data  = main_q;

  assign in_fire  = in_valid && in_ready_q && !flush;
  assign out_fire = out_valid && out_ready && !flush;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      StEmpty: begin
        if (in_fire) begin
          main_d  = in_data;
          state_d = StBusy;
        end
      end
      StBusy: begin
        if (in_fire && out_fire) begin
          main_d = in_data;
        end else if (in_fire) begin
          skid_d  = in_data;
          state_d = StFull;
        end else if (out_fire) begin
          state_d = StEmpty;
        end
      end
      StFull: begin
        if (out_fire) begin
          main_d  = skid_q;
          state_d = StBusy;
        end
      end
      default: state_d = StEmpty;
    endcase
    // Fires are already gated by flush, so only the state needs forcing.
    if (flush) begin
      state_d = StEmpty;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StEmpty;
      main_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      // Registered from next state so out_ready never reaches in_ready combinationally.
      in_ready_q <= (state_d != StFull);
    end
  end

`ifdef PIPE_SKID_STATS_EN
  logic [15:0] stall_q;

  assign stall_count = stall_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_q <= '0;
    end else if (out_valid && !out_ready && (stall_q != 16'hFFFF)) begin
      stall_q <= stall_q + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Directed, table-driven bench for pipe_skid_reg with hand-written reset and stall sequences.
module tb_pipe_skid_reg;

  localparam int DW = 16;

  logic          clk;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          flush;
`ifdef PIPE_SKID_STATS_EN
  logic [15:0]   stall_count;
`endif

  pipe_skid_reg #(
    .DATA_WIDTH(DW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .flush      (flush)
`ifdef PIPE_SKID_STATS_EN
    ,
    .stall_count(stall_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          iv;
    logic [DW-1:0] d;
    logic          ordy;
    logic          fl;
    logic          exp_ir;
    logic          exp_ov;
    logic [DW-1:0] exp_od;
  } vec_t;

  vec_t vecs[$];
  int   n_checks;
  int   n_fail;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic add(input logic iv, input logic [DW-1:0] d, input logic ordy, input logic fl,
                     input logic ir, input logic ov, input logic [DW-1:0] od);
    vec_t v;
    v.iv = iv; v.d = d; v.ordy = ordy; v.fl = fl;
    v.exp_ir = ir; v.exp_ov = ov; v.exp_od = od;
    vecs.push_back(v);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic iv, input logic [DW-1:0] d, input logic ordy, input logic fl);
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b0);

    // Each row: inputs applied before an edge, outputs expected just after it.
    //   iv    data     ordy  fl    ir    ov    od
    add(1'b1, 16'h11, 1'b1, 1'b0, 1'b1, 1'b1, 16'h11); // first beat, 1-cycle latency
    add(1'b1, 16'h01, 1'b1, 1'b0, 1'b1, 1'b1, 16'h01); // streaming
    add(1'b1, 16'h02, 1'b1, 1'b0, 1'b1, 1'b1, 16'h02);
    add(1'b1, 16'h03, 1'b1, 1'b0, 1'b1, 1'b1, 16'h03);
    add(1'b0, 16'h00, 1'b1, 1'b0, 1'b1, 1'b0, 16'h03); // drains, data holds
    add(1'b1, 16'h0A, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0A);
    add(1'b1, 16'h0B, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0A); // FULL
    add(1'b1, 16'h0D, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0A); // not accepted in FULL
    add(1'b0, 16'h00, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0B); // skid to main
    add(1'b0, 16'h00, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0B);
    add(1'b1, 16'h21, 1'b0, 1'b0, 1'b1, 1'b1, 16'h21);
    add(1'b1, 16'h22, 1'b0, 1'b0, 1'b0, 1'b1, 16'h21); // FULL
    add(1'b1, 16'h0C, 1'b1, 1'b1, 1'b1, 1'b0, 16'h21); // flush in FULL
    add(1'b0, 16'h00, 1'b1, 1'b0, 1'b1, 1'b0, 16'h21); // 0x0C never appears
    add(1'b1, 16'h31, 1'b1, 1'b0, 1'b1, 1'b1, 16'h31);
    add(1'b1, 16'h32, 1'b1, 1'b1, 1'b1, 1'b0, 16'h31); // flush in BUSY
    add(1'b1, 16'h33, 1'b1, 1'b1, 1'b1, 1'b0, 16'h31); // flush in EMPTY
    add(1'b1, 16'h34, 1'b0, 1'b0, 1'b1, 1'b1, 16'h34);
    add(1'b0, 16'h00, 1'b0, 1'b0, 1'b1, 1'b1, 16'h34); // hold under stall
    add(1'b1, 16'h35, 1'b0, 1'b0, 1'b0, 1'b1, 16'h34);
    add(1'b0, 16'h00, 1'b1, 1'b0, 1'b1, 1'b1, 16'h35);
    add(1'b1, 16'h36, 1'b1, 1'b0, 1'b1, 1'b1, 16'h36); // pass-through in BUSY
    add(1'b1, 16'h37, 1'b0, 1'b0, 1'b0, 1'b1, 16'h36);
    add(1'b0, 16'h00, 1'b1, 1'b0, 1'b1, 1'b1, 16'h37);
    add(1'b0, 16'h00, 1'b0, 1'b0, 1'b1, 1'b1, 16'h37);
    add(1'b0, 16'h00, 1'b1, 1'b0, 1'b1, 1'b0, 16'h37);

    #12;
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_in_ready", 64'(in_ready), 64'd0);
    check("reset_out_data", 64'(out_data), 64'd0);
`ifdef PIPE_SKID_STATS_EN
    check("reset_stall", 64'(stall_count), 64'd0);
`endif

    // Offer a beat across the first edge after release; it must not be taken.
    drive(1'b1, 16'h55, 1'b1, 1'b0);
    #1 reset = 1'b1;
    tick();
    check("release_in_ready", 64'(in_ready), 64'd1);
    check("release_out_valid", 64'(out_valid), 64'd0);
    check("release_out_data", 64'(out_data), 64'd0);

    foreach (vecs[i]) begin
      drive(vecs[i].iv, vecs[i].d, vecs[i].ordy, vecs[i].fl);
      tick();
      check($sformatf("vec%0d_in_ready", i), 64'(in_ready), 64'(vecs[i].exp_ir));
      check($sformatf("vec%0d_out_valid", i), 64'(out_valid), 64'(vecs[i].exp_ov));
      check($sformatf("vec%0d_out_data", i), 64'(out_data), 64'(vecs[i].exp_od));
    end

    // Asynchronous reset in BUSY clears outputs before any edge.
    drive(1'b1, 16'h41, 1'b0, 1'b0);
    tick();
    check("busy_before_rst", 64'(out_data), 64'h41);
    #2 reset = 1'b0;
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_out_data", 64'(out_data), 64'd0);
    check("midrst_in_ready", 64'(in_ready), 64'd0);
`ifdef PIPE_SKID_STATS_EN
    check("midrst_stall", 64'(stall_count), 64'd0);
`endif
    drive(1'b0, '0, 1'b1, 1'b0);
    #2 reset = 1'b1;
    tick();
    check("rerelease_in_ready", 64'(in_ready), 64'd1);
    check("rerelease_out_valid", 64'(out_valid), 64'd0);

    // One entry held for five stalled cycles, then flushed while out_ready is high.
    drive(1'b1, 16'h51, 1'b1, 1'b0);
    tick();
    check("stall_load", 64'(out_data), 64'h51);
    drive(1'b0, '0, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) tick();
    check("stall_hold_valid", 64'(out_valid), 64'd1);
    check("stall_hold_data", 64'(out_data), 64'h51);
`ifdef PIPE_SKID_STATS_EN
    check("stall_count5", 64'(stall_count), 64'd5);
`endif
    drive(1'b0, '0, 1'b1, 1'b1);
    tick();
    check("stall_flush_valid", 64'(out_valid), 64'd0);
    drive(1'b0, '0, 1'b0, 1'b0);
    tick();
    tick();
`ifdef PIPE_SKID_STATS_EN
    check("stall_after_flush", 64'(stall_count), 64'd5);
`endif
    check("final_in_ready", 64'(in_ready), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_skid_reg.md
PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 The module SHALL have parameter DATA_WIDTH, default 64: payload width in bits.
REQ-002 The module SHALL reject DATA_WIDTH < 1 with an elaboration-time assertion.
REQ-003 The module SHALL have port clk, input, 1 bit: single clock, all state updates on the rising edge.
REQ-004 The module SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 The module SHALL have port in_valid, input, 1 bit: upstream offers in_data.
REQ-006 The module SHALL have port in_ready, output, 1 bit: block can accept.
REQ-007 The module SHALL have port in_data, input, DATA_WIDTH bits: upstream payload.
REQ-008 The module SHALL have port out_valid, output, 1 bit: out_data holds a valid entry.
REQ-009 The module SHALL have port out_ready, input, 1 bit: downstream consumes.
REQ-010 The module SHALL have port out_data, output, DATA_WIDTH bits: head payload.
REQ-011 The module SHALL have port flush, input, 1 bit: synchronous discard of all entries (pipeline squash).

Function
REQ-012 The module SHALL define an input transfer (in_fire) as in_valid && in_ready && !flush, sampled at the rising edge.
REQ-013 The module SHALL define an output transfer (out_fire) as out_valid && out_ready && !flush.
REQ-014 The module SHALL hold two entries, main and skid, with states EMPTY (0), BUSY (main only) and FULL (main and skid).
REQ-015 The module SHALL drive in_ready = 1 in EMPTY and BUSY and 0 in FULL, as a registered function of state only, with no combinational path from out_ready.
REQ-016 The module SHALL drive out_valid = 1 in BUSY and FULL, and out_data from main.
REQ-017 In EMPTY, in_fire SHALL load main and move to BUSY.
REQ-018 In BUSY, in_fire && out_fire SHALL load main with in_data and stay in BUSY.
REQ-019 In BUSY, in_fire && !out_fire SHALL load skid and move to FULL.
REQ-020 In BUSY, out_fire && !in_fire SHALL move to EMPTY.
REQ-021 In FULL, out_fire SHALL copy skid into main and move to BUSY; no input is accepted in FULL.
REQ-022 Latency SHALL be 1 cycle: data accepted at edge N is on out_data after edge N with out_valid = 1.
REQ-023 Ordering SHALL be strict FIFO, with no loss or duplication while out_ready is held low indefinitely.
REQ-024 In any state, flush SHALL move the block to EMPTY at the next edge, discard main and skid, and not accept in_data that cycle regardless of in_valid.
REQ-025 out_data SHALL hold its last value when out_valid = 0 and SHALL change only on a load of main.

Reset
REQ-026 While reset = 0, the state SHALL be EMPTY, with out_valid = 0, in_ready = 0, out_data = 0 and the skid cleared, independent of clk.
REQ-027 in_ready SHALL rise on the first rising edge after reset deasserts, so no transfer occurs on that edge.
REQ-028 Reset asserted mid-operation SHALL discard all entries immediately, with no output transfer completing.

Configuration
REQ-029 With macro PIPE_SKID_STATS_EN defined, the module SHALL add output stall_count (16 bits) that increments each cycle out_valid && !out_ready, saturates at 0xFFFF, clears on reset and is unaffected by flush.
REQ-030 Without PIPE_SKID_STATS_EN, the module SHALL have no stall_count port and no counter logic, and all other behaviour SHALL be identical.

Verification
REQ-031 Reset then in_valid = 1, in_data = 0x11 with out_ready = 1 -> out_valid = 1 and out_data = 0x11 one edge later; in_ready stays 1.
REQ-032 Streaming 0x1, 0x2, 0x3 with out_ready = 1 every cycle -> outputs 0x1, 0x2, 0x3 on consecutive cycles, throughput 1 per cycle.
REQ-033 Send 0xA then 0xB with out_ready = 0 -> state FULL, in_ready = 0; raise out_ready -> 0xA, then 0xB, then out_valid = 0.
REQ-034 In FULL, assert flush together with out_ready = 1 and in_valid = 1, in_data = 0xC -> next cycle out_valid = 0, in_ready = 1, and 0xC is never output.
REQ-035 Assert reset low mid-stream in BUSY -> out_valid = 0 and out_data = 0 immediately, before the next clk edge.
REQ-036 With PIPE_SKID_STATS_EN, hold out_ready = 0 for 5 cycles with one entry present -> stall_count = 5; flush -> stall_count stays 5.
